// File: rtl/tm1638_pkg.sv
// Shared constants, FSM state type and data-byte helper for the TM1638 LED writer.
package tm1638_pkg;

  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISP_ON    = 8'h88;

  localparam int unsigned NUM_BYTES   = 19;
  localparam int unsigned LAST_BYTE   = NUM_BYTES - 1;
  localparam int unsigned GRP_B_LAST  = NUM_BYTES - 2;
  localparam int unsigned BYTE_IDX_W  = 5;
  localparam int unsigned BIT_IDX_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    STB_LO,
    BIT_LO,
    BIT_HI,
    STB_HI
  } state_t;

  // Display RAM byte at address addr: odd addresses hold one LED, even ones a segment byte.
  function automatic logic [7:0] data_byte(input logic [3:0] addr,
                                           input logic [7:0] leds,
                                           input logic [63:0] segs);
    if (addr[0]) begin
      return {7'b0, leds[addr[3:1]]};
    end
    return segs[{addr[3:1], 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/tm1638_tick.sv
// Half-bit tick generator: one-clock pulse every CLK_DIV clocks, held off while clr is high.
module tm1638_tick #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic rs,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rs || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick_c = !clr && (cnt == LAST);

endmodule

// File: rtl/tm1638_led_tx.sv
// Writes the 8-bit LED vector to a TM1638 board over STB/CLK/DIO as a 19-byte frame.
// Define TM1638_SEG_EN to add a 64-bit seg input that fills the even (segment) addresses.
module tm1638_led_tx
  import tm1638_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8,
  parameter logic [2:0]  BRIGHT  = 3'd7,
  parameter int unsigned REFRESH = 0
) (
  input  logic        clk,
  input  logic        rs,
  input  logic [7:0]  led,
`ifdef TM1638_SEG_EN
  input  logic [63:0] seg,
`endif
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int unsigned REFRESH_LAST = (REFRESH > 0) ? REFRESH - 1 : 0;

  state_t                  state;
  logic [BYTE_IDX_W-1:0]   byte_idx;
  logic [BIT_IDX_W-1:0]    bit_idx;
  logic [7:0]              cur_byte;
  logic                    stb_wait;
  logic                    init_pending;
  logic [7:0]              led_snap;
  logic [7:0]              led_sent;
  logic [RW-1:0]           refresh_cnt;
  logic [63:0]             seg_snap;
  logic                    seg_changed_c;

  logic                    tick_c;
  logic                    tick_clr_c;
  logic                    refresh_hit_c;
  logic                    start_c;
  logic                    group_end_c;
  logic [BYTE_IDX_W-1:0]   next_idx_c;
  logic [3:0]              data_addr_c;
  logic [7:0]              next_byte_c;

`ifdef TM1638_SEG_EN
  logic [63:0] seg_sent;
  assign seg_changed_c = (seg != seg_sent);
`else
  assign seg_snap      = '0;
  assign seg_changed_c = 1'b0;
`endif

  // Tick counter runs only during a frame, so it restarts from zero on every start.
  assign tick_clr_c = ~busy;

  tm1638_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rs    (rs),
    .clr   (tick_clr_c),
    .tick_c(tick_c)
  );

  assign refresh_hit_c = (REFRESH != 0) && (refresh_cnt == RW'(REFRESH_LAST));
  assign start_c       = init_pending || (led != led_sent) || seg_changed_c || refresh_hit_c;
  assign group_end_c   = (byte_idx == '0) ||
                         (byte_idx == BYTE_IDX_W'(GRP_B_LAST)) ||
                         (byte_idx == BYTE_IDX_W'(LAST_BYTE));

  // Content of the byte following the one currently on the wire.
  always_comb begin
    next_idx_c  = byte_idx + BYTE_IDX_W'(1);
    data_addr_c = 4'(next_idx_c - BYTE_IDX_W'(2));
    case (next_idx_c)
      BYTE_IDX_W'(1):         next_byte_c = CMD_ADDR0;
      BYTE_IDX_W'(LAST_BYTE): next_byte_c = CMD_DISP_ON | {5'b0, BRIGHT};
      default:                next_byte_c = data_byte(data_addr_c, led_snap, seg_snap);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      state        <= IDLE;
      tm_stb       <= 1'b1;
      tm_clk       <= 1'b1;
      tm_dio       <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      init_pending <= 1'b1;
      byte_idx     <= '0;
      bit_idx      <= '0;
      cur_byte     <= '0;
      stb_wait     <= 1'b0;
      led_snap     <= '0;
      led_sent     <= '0;
      refresh_cnt  <= '0;
`ifdef TM1638_SEG_EN
      seg_snap     <= '0;
      seg_sent     <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_c) begin
            state        <= STB_LO;
            tm_stb       <= 1'b0;
            busy         <= 1'b1;
            led_snap     <= led;
            init_pending <= 1'b0;
            byte_idx     <= '0;
            bit_idx      <= '0;
            cur_byte     <= CMD_WRITE_AUTO;
            refresh_cnt  <= '0;
`ifdef TM1638_SEG_EN
            seg_snap     <= seg;
`endif
          end else if (REFRESH != 0) begin
            refresh_cnt <= refresh_cnt + RW'(1);
          end
        end
        STB_LO: begin
          if (tick_c) begin
            state   <= BIT_LO;
            tm_clk  <= 1'b0;
            tm_dio  <= cur_byte[0];
            bit_idx <= '0;
          end
        end
        BIT_LO: begin
          if (tick_c) begin
            state  <= BIT_HI;
            tm_clk <= 1'b1;
          end
        end
        BIT_HI: begin
          if (tick_c) begin
            if (bit_idx != BIT_IDX_W'(7)) begin
              bit_idx <= bit_idx + BIT_IDX_W'(1);
              state   <= BIT_LO;
              tm_clk  <= 1'b0;
              tm_dio  <= cur_byte[bit_idx + BIT_IDX_W'(1)];
            end else if (group_end_c) begin
              state    <= STB_HI;
              tm_stb   <= 1'b1;
              stb_wait <= 1'b0;
            end else begin
              byte_idx <= next_idx_c;
              cur_byte <= next_byte_c;
              bit_idx  <= '0;
              state    <= BIT_LO;
              tm_clk   <= 1'b0;
              tm_dio   <= next_byte_c[0];
            end
          end
        end
        STB_HI: begin
          // Strobe stays high for two ticks between groups.
          if (tick_c) begin
            if (!stb_wait) begin
              stb_wait <= 1'b1;
            end else if (byte_idx == BYTE_IDX_W'(LAST_BYTE)) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              led_sent   <= led_snap;
`ifdef TM1638_SEG_EN
              seg_sent   <= seg_snap;
`endif
            end else begin
              byte_idx <= next_idx_c;
              cur_byte <= next_byte_c;
              state    <= STB_LO;
              tm_stb   <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_led_tx.sv
// Bench for tm1638_led_tx: decodes the serial stream and checks it against a frame-level model.
module tb_tm1638_led_tx;

  localparam int FRAME_CLKS = 626;
  localparam int REFRESH_R  = 1000;

  logic       clk;
  logic       rs, rs_r;
  logic [7:0] led, led_r;
  logic       tm_stb, tm_clk, tm_dio, busy, frame_done;
  logic       stb_r, clk_r, dio_r, busy_r, fd_r;

  int checks = 0;
  int errors = 0;

  tm1638_led_tx #(.CLK_DIV(2), .BRIGHT(3'd7), .REFRESH(0)) dut (
    .clk(clk), .rs(rs), .led(led),
    .tm_stb(tm_stb), .tm_clk(tm_clk), .tm_dio(tm_dio),
    .busy(busy), .frame_done(frame_done)
  );

  tm1638_led_tx #(.CLK_DIV(2), .BRIGHT(3'd7), .REFRESH(REFRESH_R)) dut_r (
    .clk(clk), .rs(rs_r), .led(led_r),
    .tm_stb(stb_r), .tm_clk(clk_r), .tm_dio(dio_r),
    .busy(busy_r), .frame_done(fd_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame byte k for a latched LED pattern (BRIGHT = 7).
  function automatic logic [7:0] exp_byte(input int k, input logic [7:0] snap);
    int a;
    if (k == 0) return 8'h40;
    if (k == 1) return 8'hC0;
    if (k == 18) return 8'h8F;
    a = k - 2;
    if (a % 2 == 1) return {7'b0, snap[a / 2]};
    return 8'h00;
  endfunction

  // Model and stream decoder state
  int         cyc = 0;
  logic       armed = 1'b0;
  logic       pending = 1'b1;
  logic [7:0] m_sent = 8'h00;
  logic [7:0] m_snap = 8'h00;
  logic       p_clk, p_stb, p_dio, p_busy, p_rs, p_fd;
  logic [7:0] p_led;
  int         t_start = 0;
  logic [7:0] cap [0:18];
  logic [7:0] last_frame [0:18];
  int         nbytes = 0, nbits = 0, ngrp = 0, stb_hi_cnt = 0;
  int         grp [0:2];
  logic [7:0] cur;
  int         done_cnt = 0;
  int         last_len = 0;

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      if (p_rs) begin
        chk("rst_stb", tm_stb, 1);
        chk("rst_clk", tm_clk, 1);
        chk("rst_dio", tm_dio, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
      end else if (!p_busy) begin
        chk("start_rule", busy, 32'(pending || (p_led != m_sent)));
      end else if (!busy) begin
        chk("busy_drop_with_done", frame_done, 1);
      end
      if (tm_stb) chk("clk_high_when_stb_high", tm_clk, 1);

      if (!p_busy && busy) begin
        m_snap  = p_led;
        pending = 1'b0;
        t_start = cyc;
        nbytes = 0; nbits = 0; ngrp = 0;
        for (int g = 0; g < 3; g++) grp[g] = 0;
      end

      if (busy || frame_done) begin
        if (!p_clk && tm_clk && !tm_stb) begin
          chk("dio_stable", tm_dio, p_dio);
          cur[nbits] = tm_dio;
          nbits++;
          if (nbits == 8) begin
            if (nbytes < 19) cap[nbytes] = cur;
            nbytes++;
            if (ngrp < 3) grp[ngrp]++;
            nbits = 0;
          end
        end
        if (!p_stb && tm_stb) ngrp++;
        if (p_stb && !tm_stb && nbytes > 0) chk("stb_gap", 32'(stb_hi_cnt >= 4), 1);
      end
      stb_hi_cnt = tm_stb ? stb_hi_cnt + 1 : 0;

      if (frame_done) begin
        last_len = cyc - t_start;
        chk("frame_len", last_len, FRAME_CLKS);
        chk("byte_count", nbytes, 19);
        chk("partial_bits", nbits, 0);
        chk("groups", ngrp, 3);
        chk("grp_a", grp[0], 1);
        chk("grp_b", grp[1], 17);
        chk("grp_c", grp[2], 1);
        for (int k = 0; k < 19; k++) begin
          chk($sformatf("byte%0d", k), cap[k], exp_byte(k, m_snap));
          last_frame[k] = cap[k];
        end
        m_sent = m_snap;
        done_cnt++;
      end
    end
    if (rs) begin
      armed   = 1'b1;
      pending = 1'b1;
    end
    p_clk = tm_clk; p_stb = tm_stb; p_dio = tm_dio;
    p_busy = busy; p_rs = rs; p_fd = frame_done; p_led = led;
  end

  // Periodic-refresh instance: frame_done period must be REFRESH + frame length.
  int cyc_r = 0;
  int last_fd_r = -1;
  int nper_r = 0;
  always @(negedge clk) begin
    cyc_r++;
    if (rs_r) begin
      last_fd_r = -1;
    end else if (fd_r) begin
      if (last_fd_r >= 0) begin
        chk("refresh_period", cyc_r - last_fd_r, REFRESH_R + FRAME_CLKS);
        nper_r++;
      end
      last_fd_r = cyc_r;
    end
  end

  task automatic wait_frames(input int n, input int bound);
    int target;
    int t;
    target = done_cnt + n;
    t = 0;
    while (done_cnt < target && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < target) chk("wait_frame_timeout", 0, 1);
  endtask

  task automatic drive(input logic [7:0] v);
    @(posedge clk);
    #1 led = v;
  endtask

  initial begin
    int t;
    int n0;
    rs = 1'b1; rs_r = 1'b1; led = 8'h00; led_r = 8'h00;
    repeat (3) @(posedge clk);
    #1 rs = 1'b0; rs_r = 1'b0;

    // Power-up frame with all LEDs off
    wait_frames(1, 2000);
    chk("f1_len", last_len, 626);
    chk("f1_b0", last_frame[0], 8'h40);
    chk("f1_b1", last_frame[1], 8'hC0);
    chk("f1_b10", last_frame[10], 8'h00);
    chk("f1_b18", last_frame[18], 8'h8F);

    // Reference pattern 0x05: addresses 1 and 5 lit
    drive(8'h05);
    wait_frames(1, 2000);
    chk("f2_addr1", last_frame[3], 8'h01);
    chk("f2_addr3", last_frame[5], 8'h00);
    chk("f2_addr5", last_frame[7], 8'h01);
    chk("f2_addr4", last_frame[6], 8'h00);

    // Three changes during a frame: only the last one is sent afterwards
    drive(8'h11);
    repeat (200) @(posedge clk);
    #1 led = 8'h22;
    repeat (200) @(posedge clk);
    #1 led = 8'hFF;
    wait_frames(1, 2000);
    chk("f3_addr1", last_frame[3], 8'h01);
    chk("f3_addr3", last_frame[5], 8'h00);
    chk("f3_addr9", last_frame[11], 8'h01);
    n0 = done_cnt;
    wait_frames(1, 2000);
    chk("f4_addr1", last_frame[3], 8'h01);
    chk("f4_addr15", last_frame[17], 8'h01);
    n0 = done_cnt;
    repeat (1500) @(posedge clk);
    @(negedge clk);
    chk("idle_no_frames", done_cnt, n0);
    chk("idle_busy", busy, 0);

    // Reset during byte 10 aborts, then a full frame is resent
    drive(8'h3C);
    t = 0;
    while (!(busy && nbytes == 10) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_byte10", 32'(busy && nbytes == 10), 1);
    @(posedge clk);
    #1 rs = 1'b1;
    @(posedge clk);
    #1 rs = 1'b0;
    @(negedge clk);
    chk("abort_stb", tm_stb, 1);
    chk("abort_clk", tm_clk, 1);
    chk("abort_busy", busy, 0);
    n0 = done_cnt;
    wait_frames(1, 2000);
    chk("resend_count", done_cnt, n0 + 1);
    chk("resend_addr1", last_frame[3], 8'h00);
    chk("resend_addr5", last_frame[7], 8'h01);
    chk("resend_b18", last_frame[18], 8'h8F);

    // Let the refresh instance show at least three periods
    t = 0;
    while (nper_r < 3 && t < 10000) begin
      @(negedge clk);
      t++;
    end
    chk("refresh_periods_seen", 32'(nper_r >= 3), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
